// File: rtl/stage3_fast_sched.sv
// -----------------------------------------------------------------------------
// stage3_fast_sched
//
// Serialising scheduler and field-dictionary owner for the stage-3 FAST encoder.
// Three input lanes are arbitrated round robin. One message at a time is
// presented to an external combinational encoder, together with the
// "previous value" dictionary (PID1/MC1/MT1). The encoded word is captured and
// handed downstream through a valid/ready port. The dictionary is then updated
// from the message just encoded. Because every encoding depends on the
// dictionary left by the previous message, only one message is in flight.
//
// Optional feature macro: STAGE3_SCHED_CNT_EN
//   defined   : msg_count counts words handed off downstream (wraps at 16 bits)
//   undefined : no counter register, msg_count is tied to 0
//
// Ports
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   in_valid[2:0]       per-lane request, bit0 = lane 1
//   in_ready[2:0]       per-lane accept, one-hot or zero, combinational in IDLE
//   message_1/_2/_3     lane messages
//   dict_clear          zero the dictionary (immediately in IDLE, else deferred)
//   enc_message         registered message presented to the encoder
//   enc_field_PID1/MC1/MT1  dictionary values presented to the encoder
//   enc_fast, enc_len   encoder result, combinational from the enc_* outputs
//   out_valid/out_ready downstream handshake
//   out_fast, out_len   registered encoded word and its length
//   out_lane            source lane of the word (0..2)
//   msg_count           handed-off word count
// -----------------------------------------------------------------------------
module stage3_fast_sched #(
   parameter int MSG_W   = 256,
   parameter int FIELD_W = 8,
   parameter int PID_LSB = 16,
   parameter int MC_LSB  = 8,
   parameter int MT_LSB  = 0,
   parameter int FAST_W  = 344,
   parameter int LEN_W   = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [2:0]         in_valid,
   output logic [2:0]         in_ready,
   input  logic [MSG_W-1:0]   message_1,
   input  logic [MSG_W-1:0]   message_2,
   input  logic [MSG_W-1:0]   message_3,
   input  logic               dict_clear,
   output logic [MSG_W-1:0]   enc_message,
   output logic [FIELD_W-1:0] enc_field_PID1,
   output logic [FIELD_W-1:0] enc_field_MC1,
   output logic [FIELD_W-1:0] enc_field_MT1,
   input  logic [FAST_W-1:0]  enc_fast,
   input  logic [LEN_W-1:0]   enc_len,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [FAST_W-1:0]  out_fast,
   output logic [LEN_W-1:0]   out_len,
   output logic [1:0]         out_lane,
   output logic [15:0]        msg_count
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_LOAD = 2'd1,
      S_EMIT = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic [MSG_W-1:0]   msg_q, msg_d;
   logic [1:0]         lane_q, lane_d;
   logic [1:0]         rr_q, rr_d;          // last granted lane
   logic [FAST_W-1:0]  fast_q, fast_d;
   logic [LEN_W-1:0]   len_q, len_d;
   logic               valid_q, valid_d;
   logic [FIELD_W-1:0] pid_q, pid_d;
   logic [FIELD_W-1:0] mc_q, mc_d;
   logic [FIELD_W-1:0] mt_q, mt_d;
   logic               clr_pend_q, clr_pend_d;

   // ---------------------------------------------------------------------------
   // Round-robin arbitration. Candidates are ordered starting from the lane
   // after the last grant; the earliest requesting candidate wins.
   // ---------------------------------------------------------------------------
   function automatic logic [1:0] next_lane(input logic [1:0] l);
      return (l == 2'd2) ? 2'd0 : l + 2'd1;
   endfunction

   logic [3:0] req_ext;
   logic [1:0] cand0, cand1, cand2;
   logic       grant_vld;
   logic [1:0] grant_idx;
   logic [MSG_W-1:0] grant_msg;

   assign req_ext = {1'b0, in_valid};

   always_comb begin
      cand0     = next_lane(rr_q);
      cand1     = next_lane(cand0);
      cand2     = next_lane(cand1);
      grant_vld = |in_valid;
      grant_idx = cand2;
      if (req_ext[cand1]) grant_idx = cand1;
      if (req_ext[cand0]) grant_idx = cand0;
   end

   always_comb begin
      case (grant_idx)
         2'd0:    grant_msg = message_1;
         2'd1:    grant_msg = message_2;
         default: grant_msg = message_3;
      endcase
   end

   // Accept strobes exist only in IDLE; LOAD/EMIT never grant.
   genvar gi;
   generate
      for (gi = 0; gi < 3; gi++) begin : g_ready
         assign in_ready[gi] = (state_q == S_IDLE) && grant_vld && (grant_idx == 2'(gi));
      end
   endgenerate

   // ---------------------------------------------------------------------------
   // Next-state logic
   // ---------------------------------------------------------------------------
   always_comb begin
      state_d    = state_q;
      msg_d      = msg_q;
      lane_d     = lane_q;
      rr_d       = rr_q;
      fast_d     = fast_q;
      len_d      = len_q;
      valid_d    = valid_q;
      pid_d      = pid_q;
      mc_d       = mc_q;
      mt_d       = mt_q;
      clr_pend_d = clr_pend_q;

      case (state_q)
         S_IDLE: begin
            // Clear lands on this edge, so a message granted now is encoded
            // against the zeroed dictionary in LOAD.
            if (dict_clear) begin
               pid_d      = '0;
               mc_d       = '0;
               mt_d       = '0;
               clr_pend_d = 1'b0;
            end
            if (grant_vld) begin
               msg_d   = grant_msg;
               lane_d  = grant_idx;
               rr_d    = grant_idx;
               state_d = S_LOAD;
            end
         end

         S_LOAD: begin
            fast_d  = enc_fast;
            len_d   = enc_len;
            pid_d   = msg_q[PID_LSB +: FIELD_W];
            mc_d    = msg_q[MC_LSB  +: FIELD_W];
            mt_d    = msg_q[MT_LSB  +: FIELD_W];
            valid_d = 1'b1;
            state_d = S_EMIT;
            // A clear seen now must not disturb this update; defer it.
            if (dict_clear) clr_pend_d = 1'b1;
         end

         S_EMIT: begin
            if (dict_clear) clr_pend_d = 1'b1;
            if (out_ready) begin
               valid_d = 1'b0;
               state_d = S_IDLE;
               // A clear arriving on the handshake edge itself is honoured too.
               if (clr_pend_q || dict_clear) begin
                  pid_d = '0;
                  mc_d  = '0;
                  mt_d  = '0;
               end
               clr_pend_d = 1'b0;
            end
         end

         default: begin
            state_d = S_IDLE;
            valid_d = 1'b0;
         end
      endcase
   end

   // ---------------------------------------------------------------------------
   // State registers
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         msg_q      <= '0;
         lane_q     <= '0;
         rr_q       <= 2'd2;   // so that lane 0 is considered first
         fast_q     <= '0;
         len_q      <= '0;
         valid_q    <= 1'b0;
         pid_q      <= '0;
         mc_q       <= '0;
         mt_q       <= '0;
         clr_pend_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         msg_q      <= msg_d;
         lane_q     <= lane_d;
         rr_q       <= rr_d;
         fast_q     <= fast_d;
         len_q      <= len_d;
         valid_q    <= valid_d;
         pid_q      <= pid_d;
         mc_q       <= mc_d;
         mt_q       <= mt_d;
         clr_pend_q <= clr_pend_d;
      end
   end

   // ---------------------------------------------------------------------------
   // Handed-off word counter
   // ---------------------------------------------------------------------------
`ifdef STAGE3_SCHED_CNT_EN
   logic [15:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if ((state_q == S_EMIT) && out_ready) cnt_d = cnt_q + 16'd1;  // wraps naturally
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) cnt_q <= '0;
      else        cnt_q <= cnt_d;
   end

   assign msg_count = cnt_q;
`else
   assign msg_count = '0;
`endif

   // ---------------------------------------------------------------------------
   // Outputs
   // ---------------------------------------------------------------------------
   assign enc_message    = msg_q;
   assign enc_field_PID1 = pid_q;
   assign enc_field_MC1  = mc_q;
   assign enc_field_MT1  = mt_q;
   assign out_valid      = valid_q;
   assign out_fast       = fast_q;
   assign out_len        = len_q;
   assign out_lane       = lane_q;

endmodule

// File: tb/tb_stage3_fast_sched.sv
// -----------------------------------------------------------------------------
// tb_stage3_fast_sched
//
// Directed bench for stage3_fast_sched. A small stand-in encoder builds a
// header {1, pid_match, mc_match, mt_match, 12'h000}, a length of 2 plus one
// per mismatching field, and carries the message in the low bits. Stimulus
// pushes hand-computed expected words into a queue; a monitor pops and
// compares on every downstream handshake.
// -----------------------------------------------------------------------------
module tb_stage3_fast_sched;

   logic         clk = 1'b0;
   logic         rst_n;
   logic [2:0]   in_valid;
   logic [2:0]   in_ready;
   logic [255:0] m0, m1, m2;
   logic         dict_clear;
   logic [255:0] enc_message;
   logic [7:0]   enc_field_PID1, enc_field_MC1, enc_field_MT1;
   logic [343:0] enc_fast;
   logic [7:0]   enc_len;
   logic         out_valid;
   logic         out_ready;
   logic [343:0] out_fast;
   logic [7:0]   out_len;
   logic [1:0]   out_lane;
   logic [15:0]  msg_count;

   int checks = 0;
   int errors = 0;
   int hs_cnt = 0;

   typedef struct {
      logic [343:0] fast;
      logic [7:0]   len;
      logic [1:0]   lane;
   } exp_t;

   exp_t exp_q[$];

   always #5 clk = ~clk;

   stage3_fast_sched dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .in_valid       (in_valid),
      .in_ready       (in_ready),
      .message_1      (m0),
      .message_2      (m1),
      .message_3      (m2),
      .dict_clear     (dict_clear),
      .enc_message    (enc_message),
      .enc_field_PID1 (enc_field_PID1),
      .enc_field_MC1  (enc_field_MC1),
      .enc_field_MT1  (enc_field_MT1),
      .enc_fast       (enc_fast),
      .enc_len        (enc_len),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .out_fast       (out_fast),
      .out_len        (out_len),
      .out_lane       (out_lane),
      .msg_count      (msg_count)
   );

   // Stand-in combinational encoder
   logic [15:0] hdr_m;
   logic [7:0]  len_m;
   always_comb begin
      hdr_m = 16'h8000;
      len_m = 8'd2;
      if (enc_message[23:16] == enc_field_PID1) hdr_m[14] = 1'b1; else len_m = len_m + 8'd1;
      if (enc_message[15:8]  == enc_field_MC1)  hdr_m[13] = 1'b1; else len_m = len_m + 8'd1;
      if (enc_message[7:0]   == enc_field_MT1)  hdr_m[12] = 1'b1; else len_m = len_m + 8'd1;
   end
   assign enc_fast = {hdr_m, 72'h0, enc_message};
   assign enc_len  = len_m;

   function automatic logic [255:0] mk_msg(input logic [31:0] tag, input logic [23:0] f);
      return {200'h0, tag, f};
   endfunction

   task automatic chk(input string name, input logic [343:0] act, input logic [343:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic push(input logic [15:0] hdr, input logic [7:0] len,
                       input logic [1:0] lane, input logic [255:0] msg);
      exp_t e;
      e.fast = {hdr, 72'h0, msg};
      e.len  = len;
      e.lane = lane;
      exp_q.push_back(e);
   endtask

   function automatic logic [15:0] exp_count();
`ifdef STAGE3_SCHED_CNT_EN
      return hs_cnt[15:0];
`else
      return 16'd0;
`endif
   endfunction

   // Scoreboard monitor: one compare per handshake
   always @(negedge clk) begin
      if (!rst_n) begin
         hs_cnt = 0;
      end else if (out_valid && out_ready) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_word actual_lane=%0d actual_len=%0d required=none", out_lane, out_len);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            if (out_fast !== e.fast || out_len !== e.len || out_lane !== e.lane) begin
               errors++;
               $display("FAIL word actual hdr=%0h len=%0d lane=%0d low=%0h required hdr=%0h len=%0d lane=%0d low=%0h",
                        out_fast[343:328], out_len, out_lane, out_fast[255:0],
                        e.fast[343:328], e.len, e.lane, e.fast[255:0]);
            end else begin
               $display("word lane=%0d hdr=%0h len=%0d ok", out_lane, out_fast[343:328], out_len);
            end
         end
         hs_cnt = hs_cnt + 1;
      end
   end

   // Request lane, wait for its accept, drop the request after the accept edge.
   task automatic send(input int lane, input logic [255:0] m);
      int n;
      case (lane)
         0:       m0 = m;
         1:       m1 = m;
         default: m2 = m;
      endcase
      in_valid[lane] = 1'b1;
      n = 0;
      @(negedge clk);
      while (in_ready[lane] !== 1'b1 && n < 30) begin
         @(negedge clk);
         n++;
      end
      if (n >= 30) begin
         checks++;
         errors++;
         $display("FAIL accept_timeout lane=%0d actual=no_ready required=ready", lane);
      end
      @(posedge clk);
      #1 in_valid[lane] = 1'b0;
   endtask

   // Wait until the scoreboard drains, then until the DUT is back in IDLE.
   task automatic wait_done();
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 60) begin
         @(posedge clk);
         n++;
      end
      if (n >= 60) begin
         checks++;
         errors++;
         $display("FAIL drain_timeout actual_pending=%0d required=0", exp_q.size());
         exp_q.delete();
      end
      @(posedge clk);
      #1;
   endtask

   logic [255:0] msg_a, msg_b, msg_c, msg_d, msg_e, msg_f, msg_g, msg_h, msg_i, msg_r;
   logic [2:0]   exp_grant;

   initial begin
      rst_n      = 1'b0;
      in_valid   = 3'b000;
      out_ready  = 1'b1;
      dict_clear = 1'b0;
      m0 = '0; m1 = '0; m2 = '0;
      msg_a = mk_msg(32'hA0A0_0001, 24'h000000);
      msg_b = mk_msg(32'hB0B0_0002, 24'h050709);
      msg_c = mk_msg(32'hC0C0_0003, 24'h050709);
      msg_d = mk_msg(32'hD0D0_0004, 24'h000000);
      msg_e = mk_msg(32'hE0E0_0005, 24'h010000);
      msg_f = mk_msg(32'hF0F0_0006, 24'h010000);
      msg_g = mk_msg(32'h1111_0007, 24'h000000);
      msg_h = mk_msg(32'h2222_0008, 24'h000102);
      msg_i = mk_msg(32'h3333_0009, 24'h000100);
      msg_r = mk_msg(32'h4444_000A, 24'h0A0B0C);

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      chk("rst_in_ready",  344'(in_ready), 344'(3'b000));
      chk("rst_out_valid", 344'(out_valid), 344'(1'b0));
      chk("rst_out_fast",  out_fast, 344'h0);
      chk("rst_out_len",   344'(out_len), 344'(8'd0));
      chk("rst_out_lane",  344'(out_lane), 344'(2'd0));
      chk("rst_enc_msg",   344'(enc_message), 344'h0);
      chk("rst_dict",      344'({enc_field_PID1, enc_field_MC1, enc_field_MT1}), 344'h0);
      chk("rst_count",     344'(msg_count), 344'(16'd0));
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // All fields match the zero dictionary; check two-edge latency
      push(16'hF000, 8'd2, 2'd0, msg_a);
      send(0, msg_a);
      chk("lat_load_valid", 344'(out_valid), 344'(1'b0));
      @(posedge clk);
      #1;
      chk("lat_emit_valid", 344'(out_valid), 344'(1'b1));
      wait_done();

      // Dictionary update then match
      push(16'h8000, 8'd5, 2'd0, msg_b);
      send(0, msg_b);
      wait_done();
      chk("dict_pid", 344'(enc_field_PID1), 344'(8'd5));
      chk("dict_mc",  344'(enc_field_MC1),  344'(8'd7));
      chk("dict_mt",  344'(enc_field_MT1),  344'(8'd9));
      push(16'hF000, 8'd2, 2'd0, msg_b);
      send(0, msg_b);
      wait_done();

      // Deferred clear during EMIT
      out_ready = 1'b0;
      push(16'hF000, 8'd2, 2'd0, msg_c);
      send(0, msg_c);
      @(posedge clk);
      #1 dict_clear = 1'b1;
      @(posedge clk);
      #1 dict_clear = 1'b0;
      chk("defer_dict_held", 344'(enc_field_PID1), 344'(8'd5));
      out_ready = 1'b1;
      wait_done();
      chk("defer_dict_zero", 344'({enc_field_PID1, enc_field_MC1, enc_field_MT1}), 344'h0);
      push(16'hF000, 8'd2, 2'd0, msg_d);
      send(0, msg_d);
      wait_done();

      // Back-pressure for 10 cycles with lane 2 requesting
      out_ready = 1'b0;
      push(16'hB000, 8'd3, 2'd1, msg_e);
      push(16'hF000, 8'd2, 2'd2, msg_f);
      m2 = msg_f;
      in_valid[2] = 1'b1;
      send(1, msg_e);
      @(posedge clk);
      #1;
      for (int c = 0; c < 10; c++) begin
         chk("bp_in_ready",  344'(in_ready), 344'(3'b000));
         chk("bp_out_valid", 344'(out_valid), 344'(1'b1));
         chk("bp_out_fast",  out_fast, {16'hB000, 72'h0, msg_e});
         chk("bp_out_lane",  344'(out_lane), 344'(2'd1));
         chk("bp_count",     344'(msg_count), 344'(exp_count()));
         @(posedge clk);
         #1;
      end
      out_ready = 1'b1;
      begin
         int n;
         n = 0;
         @(negedge clk);
         while (in_ready[2] !== 1'b1 && n < 30) begin
            @(negedge clk);
            n++;
         end
         chk("bp_lane2_grant", 344'(in_ready), 344'(3'b100));
         @(posedge clk);
         #1 in_valid[2] = 1'b0;
      end
      wait_done();
      chk("bp_count_after", 344'(msg_count), 344'(exp_count()));

      // Arbitration with all lanes requesting
      m0 = msg_g; m1 = msg_h; m2 = msg_i;
      push(16'hB000, 8'd3, 2'd0, msg_g);
      push(16'hC000, 8'd4, 2'd1, msg_h);
      push(16'hE000, 8'd3, 2'd2, msg_i);
      push(16'hD000, 8'd3, 2'd0, msg_g);
      in_valid = 3'b111;
      for (int k = 0; k < 4; k++) begin
         int n;
         case (k)
            0:       exp_grant = 3'b001;
            1:       exp_grant = 3'b010;
            2:       exp_grant = 3'b100;
            default: exp_grant = 3'b001;
         endcase
         n = 0;
         @(negedge clk);
         while (in_ready == 3'b000 && n < 30) begin
            @(negedge clk);
            n++;
         end
         chk("arb_grant", 344'(in_ready), 344'(exp_grant));
         @(posedge clk);
         if (k == 3) #1 in_valid = 3'b000;
      end
      wait_done();

      // Clear in IDLE together with a grant: encoded against zeroed dictionary
      push(16'h8000, 8'd5, 2'd0, msg_b);
      send(0, msg_b);
      wait_done();
      push(16'h8000, 8'd5, 2'd0, msg_b);
      dict_clear = 1'b1;
      send(0, msg_b);
      dict_clear = 1'b0;
      wait_done();
      chk("idle_clear_dict", 344'(enc_field_MC1), 344'(8'd7));

      // Reset during EMIT drops the word
      out_ready = 1'b0;
      send(0, msg_r);
      @(posedge clk);
      #1;
      chk("mid_valid_before", 344'(out_valid), 344'(1'b1));
      rst_n = 1'b0;
      #1;
      chk("mid_valid_after", 344'(out_valid), 344'(1'b0));
      chk("mid_dict", 344'({enc_field_PID1, enc_field_MC1, enc_field_MT1}), 344'h0);
      chk("mid_count", 344'(msg_count), 344'(16'd0));
      chk("mid_out_len", 344'(out_len), 344'(8'd0));
      @(posedge clk);
      #1 rst_n = 1'b1;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      chk("mid_no_resend", 344'(out_valid), 344'(1'b0));

      // Recovery after reset
      push(16'hF000, 8'd2, 2'd0, msg_a);
      send(0, msg_a);
      wait_done();
      chk("final_count", 344'(msg_count), 344'(exp_count()));
      chk("queue_empty", 344'(exp_q.size()), 344'(0));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   // Global time limit
   initial begin
      #200000;
      $display("FAIL global_timeout actual=running required=finished");
      $fatal(1, "timeout");
   end

endmodule
